// File: rtl/data_sram_responder.sv
// Data SRAM responder: zero-fill sweep after reset, then byte-strobed writes and registered reads.
// Latency: read data appears on data_sram_rdata the cycle after the request; writes land at the request edge.
// Backpressure: none; one request per cycle is always accepted in RUN, and requests during INIT are ignored.
module data_sram_responder #(
    parameter int          ADDR_W     = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        init_done,
    output logic        addr_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                init_done_q, init_done_d;
    logic                addr_err_q, addr_err_d;
    logic [31:0]         rd_cnt_q, rd_cnt_d;
    logic [31:0]         wr_cnt_q, wr_cnt_d;
    logic [31:0]         rdata_q;

    logic [31:0]         mem [DEPTH];

    // Single RAM port shared by the init sweep and the request path.
    logic [3:0]          mem_be;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_wdata;
    logic                mem_rd;
    logic                rdata_clr;

    logic                in_win;
    logic [ADDR_W-1:0]   req_idx;
    logic                unused_addr_lsbs;

    assign in_win           = (data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign req_idx          = data_sram_addr[ADDR_W+1:2];
    // Byte offset is irrelevant: lanes are chosen by the write strobes alone.
    assign unused_addr_lsbs = ^data_sram_addr[1:0];

    // Next-state, counters, error flag and RAM port selection.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        addr_err_d  = addr_err_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        mem_be      = 4'h0;
        mem_addr    = req_idx;
        mem_wdata   = data_sram_wdata;
        mem_rd      = 1'b0;
        rdata_clr   = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_INIT: begin
                    mem_be    = 4'hF;
                    mem_addr  = idx_q;
                    mem_wdata = INIT_VALUE;
                    idx_d     = idx_q + 1'b1;
                    if (&idx_q) begin
                        state_d     = ST_RUN;
                        init_done_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (data_sram_en) begin
                        if (in_win) begin
                            if (data_sram_we != 4'h0) begin
                                mem_be   = data_sram_we;
                                wr_cnt_d = wr_cnt_q + 32'd1;
                            end else begin
                                mem_rd   = 1'b1;
                                rd_cnt_d = rd_cnt_q + 32'd1;
                            end
                        end else begin
                            // Out-of-window: drop writes, return zero for reads.
                            addr_err_d = 1'b1;
                            rdata_clr  = (data_sram_we == 4'h0);
                        end
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            addr_err_q  <= 1'b0;
            rd_cnt_q    <= 32'd0;
            wr_cnt_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            addr_err_q  <= addr_err_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    // Registered read port; reads the pre-write contents on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 32'd0;
        end else if (mem_rd) begin
            rdata_q <= mem[mem_addr];
        end else if (rdata_clr) begin
            rdata_q <= 32'd0;
        end
    end

    // Byte-enabled RAM write; contents are never reset, the sweep overwrites them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_be[i]) begin
                mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign init_done       = init_done_q;
    assign addr_err        = addr_err_q;
    assign rd_cnt          = rd_cnt_q;
    assign wr_cnt          = wr_cnt_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder with a 16-word window filled with DEADBEEF.
// Latency: each request is driven for one edge and results are sampled 1 time unit after it.
// Backpressure: not applicable; the responder accepts every request.
module tb_data_sram_responder;

    localparam int          AW   = 4;
    localparam logic [31:0] INIT = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        init_done;
    logic        addr_err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    data_sram_responder #(
        .ADDR_W    (AW),
        .BASE_ADDR (32'h0000_0000),
        .INIT_VALUE(INIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .data_sram_en   (en),
        .data_sram_we   (we),
        .data_sram_addr (addr),
        .data_sram_wdata(wdata),
        .data_sram_rdata(rdata),
        .init_done      (init_done),
        .addr_err       (addr_err),
        .rd_cnt         (rd_cnt),
        .wr_cnt         (wr_cnt)
    );

    always #5 clk = ~clk;

    // One request for one edge; outputs are stable on return.
    task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        en = 1'b0; we = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic reset_and_init();
        reset = 1'b1; en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (init_done) break;
        end
        tests_run++;
        if (init_done !== 1'b1) begin tests_failed++; $display("FAIL init_timeout: init_done=%b want 1", init_done); end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (rdata !== 32'h0)     begin tests_failed++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        tests_run++; if (init_done !== 1'b0)  begin tests_failed++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        tests_run++; if (addr_err !== 1'b0)   begin tests_failed++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
        tests_run++; if (rd_cnt !== 32'h0)    begin tests_failed++; $display("FAIL reset_rd_cnt: got %h want 0", rd_cnt); end
        tests_run++; if (wr_cnt !== 32'h0)    begin tests_failed++; $display("FAIL reset_wr_cnt: got %h want 0", wr_cnt); end
    endtask

    task automatic test_init();
        int cyc;
        cyc = 0;
        reset = 1'b0;
        // Write issued during the sweep must be ignored.
        en = 1'b1; we = 4'hF; addr = 32'h8; wdata = 32'h1234_5678;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            en = 1'b0; we = 4'h0;
            if (init_done) begin cyc = n; break; end
        end
        tests_run++; if (cyc != 16)         begin tests_failed++; $display("FAIL init_latency: got %0d want 16", cyc); end
        tests_run++; if (wr_cnt !== 32'h0)  begin tests_failed++; $display("FAIL init_wr_cnt: got %h want 0", wr_cnt); end
        req(4'h0, 32'h0, 32'h0);
        tests_run++; if (rdata !== INIT)    begin tests_failed++; $display("FAIL init_word0: got %h want %h", rdata, INIT); end
        req(4'h0, 32'h3C, 32'h0);
        tests_run++; if (rdata !== INIT)    begin tests_failed++; $display("FAIL init_word15: got %h want %h", rdata, INIT); end
        req(4'h0, 32'h8, 32'h0);
        tests_run++; if (rdata !== INIT)    begin tests_failed++; $display("FAIL init_ignored_write: got %h want %h", rdata, INIT); end
        tests_run++; if (rd_cnt !== 32'd3)  begin tests_failed++; $display("FAIL init_rd_cnt: got %h want 3", rd_cnt); end
    endtask

    task automatic test_byte_strobe();
        reset_and_init();
        req(4'b1111, 32'h10, 32'h1122_3344);
        req(4'b0100, 32'h10, 32'hAAAA_AAAA);
        req(4'b0000, 32'h10, 32'h0);
        tests_run++; if (rdata !== 32'h11AA_3344) begin tests_failed++; $display("FAIL strobe_rdata: got %h want 11aa3344", rdata); end
        tests_run++; if (wr_cnt !== 32'd2)        begin tests_failed++; $display("FAIL strobe_wr_cnt: got %h want 2", wr_cnt); end
        tests_run++; if (rd_cnt !== 32'd1)        begin tests_failed++; $display("FAIL strobe_rd_cnt: got %h want 1", rd_cnt); end
    endtask

    task automatic test_latency_hold();
        req(4'hF, 32'h4, 32'h5);
        req(4'h0, 32'h4, 32'h0);
        tests_run++; if (rdata !== 32'h5) begin tests_failed++; $display("FAIL hold_c1: got %h want 5", rdata); end
        for (int i = 2; i <= 4; i++) begin
            idle(1);
            tests_run++; if (rdata !== 32'h5) begin tests_failed++; $display("FAIL hold_c%0d: got %h want 5", i, rdata); end
        end
        // Write then read of the same word.
        req(4'hF, 32'h8, 32'hCAFE_F00D);
        req(4'h0, 32'h8, 32'h0);
        tests_run++; if (rdata !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL wr_then_rd: got %h want cafef00d", rdata); end
        // Read then write of the same word.
        req(4'h0, 32'h8, 32'h0);
        req(4'hF, 32'h8, 32'h0BAD_0BAD);
        tests_run++; if (rdata !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL rd_then_wr: got %h want cafef00d", rdata); end
        req(4'h0, 32'h8, 32'h0);
        tests_run++; if (rdata !== 32'h0BAD_0BAD) begin tests_failed++; $display("FAIL rd_after_wr: got %h want 0bad0bad", rdata); end
        // Reads on every cycle.
        req(4'h0, 32'h4, 32'h0);
        tests_run++; if (rdata !== 32'h5)         begin tests_failed++; $display("FAIL stream_0: got %h want 5", rdata); end
        req(4'h0, 32'h10, 32'h0);
        tests_run++; if (rdata !== 32'h11AA_3344) begin tests_failed++; $display("FAIL stream_1: got %h want 11aa3344", rdata); end
        req(4'h0, 32'h8, 32'h0);
        tests_run++; if (rdata !== 32'h0BAD_0BAD) begin tests_failed++; $display("FAIL stream_2: got %h want 0bad0bad", rdata); end
        tests_run++; if (wr_cnt !== 32'd5)        begin tests_failed++; $display("FAIL hold_wr_cnt: got %h want 5", wr_cnt); end
        tests_run++; if (rd_cnt !== 32'd8)        begin tests_failed++; $display("FAIL hold_rd_cnt: got %h want 8", rd_cnt); end
        tests_run++; if (addr_err !== 1'b0)       begin tests_failed++; $display("FAIL hold_addr_err: got %b want 0", addr_err); end
    endtask

    task automatic test_out_of_window();
        req(4'hF, 32'h40, 32'hFFFF_FFFF);
        tests_run++; if (addr_err !== 1'b1)     begin tests_failed++; $display("FAIL oow_wr_err: got %b want 1", addr_err); end
        req(4'h0, 32'h40, 32'h0);
        tests_run++; if (rdata !== 32'h0)       begin tests_failed++; $display("FAIL oow_rdata: got %h want 0", rdata); end
        tests_run++; if (wr_cnt !== 32'd5)      begin tests_failed++; $display("FAIL oow_wr_cnt: got %h want 5", wr_cnt); end
        tests_run++; if (rd_cnt !== 32'd8)      begin tests_failed++; $display("FAIL oow_rd_cnt: got %h want 8", rd_cnt); end
        req(4'h0, 32'h0, 32'h0);
        tests_run++; if (rdata !== INIT)        begin tests_failed++; $display("FAIL oow_storage: got %h want %h", rdata, INIT); end
        tests_run++; if (addr_err !== 1'b1)     begin tests_failed++; $display("FAIL oow_sticky: got %b want 1", addr_err); end
        tests_run++; if (rd_cnt !== 32'd9)      begin tests_failed++; $display("FAIL oow_rd_after: got %h want 9", rd_cnt); end
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        cyc = 0;
        reset = 1'b1; en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        idle(7);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests_run++; if (rdata !== 32'h0)    begin tests_failed++; $display("FAIL mid_rdata: got %h want 0", rdata); end
        tests_run++; if (rd_cnt !== 32'h0)   begin tests_failed++; $display("FAIL mid_rd_cnt: got %h want 0", rd_cnt); end
        tests_run++; if (wr_cnt !== 32'h0)   begin tests_failed++; $display("FAIL mid_wr_cnt: got %h want 0", wr_cnt); end
        tests_run++; if (addr_err !== 1'b0)  begin tests_failed++; $display("FAIL mid_addr_err: got %b want 0", addr_err); end
        tests_run++; if (init_done !== 1'b0) begin tests_failed++; $display("FAIL mid_init_done: got %b want 0", init_done); end
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (init_done) begin cyc = n; break; end
        end
        tests_run++; if (cyc != 16) begin tests_failed++; $display("FAIL mid_latency: got %0d want 16", cyc); end
        req(4'h0, 32'h8, 32'h0);
        tests_run++; if (rdata !== INIT) begin tests_failed++; $display("FAIL mid_refill: got %h want %h", rdata, INIT); end
    endtask

    task automatic test_counter_wrap();
        dut.wr_cnt_q = 32'hFFFF_FFFF;
        req(4'hF, 32'h14, 32'h0000_0077);
        tests_run++; if (wr_cnt !== 32'h0) begin tests_failed++; $display("FAIL wrap_wr_cnt: got %h want 0", wr_cnt); end
        req(4'h0, 32'h14, 32'h0);
        tests_run++; if (rdata !== 32'h77) begin tests_failed++; $display("FAIL wrap_write_data: got %h want 77", rdata); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_byte_strobe();
        test_latency_hold();
        test_out_of_window();
        test_reset_mid_sweep();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Memory-side responder for the data SRAM request port driven by the execute stage.
- Accepts single-cycle en/we/addr/wdata requests, performs byte-strobed writes, and returns read data one cycle later on data_sram_rdata. The memory stage samples that data.
- Contains a post-reset init sweep that zero-fills storage, an address-window check with a sticky error flag, and access counters for bring-up and debug.
- Sits at the top level between the CPU core's data port and the simulation/FPGA environment.

Parameters:
- ADDR_W, 12: word-index width; DEPTH = 2^ADDR_W 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte base of the window; only bits [31:ADDR_W+2] are significant.
- INIT_VALUE, 32'h0000_0000: word written to every entry during the init sweep.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- data_sram_en  in  1  request valid this cycle
- data_sram_we  in  4  byte write strobes; 0 = read
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  write data, already lane-replicated by the requester
- data_sram_rdata  out  32  read data, valid the cycle after a read request
- init_done  out  1  high once the init sweep is complete; the top level holds CPU reset until it is high
- addr_err  out  1  sticky: an out-of-window request was seen
- rd_cnt  out  32  accepted read count
- wr_cnt  out  32  accepted write count

Behaviour:
- Clocking and reset: all state updates on posedge clk; reset is synchronous, active-high.
- Reset values: data_sram_rdata=0, init_done=0, addr_err=0, rd_cnt=0, wr_cnt=0, FSM=INIT, sweep index=0. Storage contents are not reset directly; the sweep overwrites them.
- FSM states INIT and RUN:
  - INIT: each cycle write INIT_VALUE to mem[idx] (all 4 lanes), then idx++.
  - When idx==DEPTH-1 is written, go to RUN next cycle.
  - init_done is registered: it goes high exactly DEPTH cycles after the first cycle with reset low.
  - RUN: stays in RUN until reset.
- Reset mid-sweep or mid-run: FSM returns to INIT, idx=0, and all outputs return to their reset values. The sweep restarts from word 0.
- Requests during INIT: ignored entirely. No write, no rdata update, no counter change, no addr_err.
- Address decode:
  - in_win = (addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]).
  - word index = addr[ADDR_W+1:2].
  - addr[1:0] is ignored; lane selection comes only from we.
- Write (RUN, en=1, we!=0, in_win): for each i with we[i]=1, mem[idx][8i+7:8i] <= wdata[8i+7:8i]. Other lanes are unchanged, rdata is unchanged, wr_cnt increments.
- Read (RUN, en=1, we==0, in_win): rdata <= mem[idx] at the same edge, so data is visible the cycle after the request (1-cycle latency). rd_cnt increments.
- Back-to-back accesses:
  - Write then read of the same word on consecutive cycles returns the new data.
  - A read every cycle is supported at full throughput.
  - A read then write of the same word returns the pre-write data.
- No request (en=0): rdata holds its last value; we and wdata are don't-care.
- Out-of-window request (RUN, en=1, !in_win):
  - A write is dropped.
  - A read sets rdata <= 32'h0.
  - addr_err <= 1 and stays high until reset.
  - Counters do not change.
- Counters wrap modulo 2^32; there is no saturation.
- Storage: inferable as a single-port synchronous RAM with byte enables. The INIT-sweep write port is muxed onto the same port.

Test Plan:
- Init sweep (ADDR_W=4, INIT_VALUE=32'hDEAD_BEEF): release reset. Required: init_done rises exactly 16 cycles later. Reads of word 0 and word 15 return 32'hDEAD_BEEF. A write to 0x8 issued during INIT has no effect and leaves wr_cnt=0.
- Byte-strobe write and read-back:
  - Write 0x1122_3344 with we=4'b1111 to 0x10.
  - Write wdata 0xAAAA_AAAA with we=4'b0100 to 0x10.
  - Read 0x10. Required: rdata=0x11AA_3344 one cycle later, wr_cnt=2, rd_cnt=1.
- Read latency and hold:
  - Read 0x4, which holds 0x5, then keep en=0 for 3 cycles. Required: rdata=0x5 from cycle+1 through cycle+4.
  - Then read/write 0x8 back-to-back. Required: the read-then-write ordering returns the old value.
- Out-of-window access (BASE=0, ADDR_W=4): write 0x0000_0040 with we=4'hF, then read it. Required: storage is unchanged, rdata=0, addr_err=1 and stays high, counters are unchanged.
- Reset mid-sweep: assert reset for 1 cycle while idx=7. Required: rdata=0, counters=0, addr_err=0, init_done low, and init_done rises 16 cycles after reset deasserts.
- Counter wrap: force wr_cnt=32'hFFFF_FFFF, then do one valid write. Required: wr_cnt=0.
